// File: rtl/mb_record_reader.sv
// Read side of the per-macroblock result FIFO: gathers the 7 beats of each record
// into one register and presents it downstream with its macroblock coordinates.
module mb_record_reader #(
    parameter int BEATS = 7,
    parameter int DW    = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [9:0]        w1,
    input  logic [9:0]        h1,
    input  logic              fifo_empty,
    input  logic [DW-1:0]     fifo_dout,
    output logic              fifo_rd,
    output logic              mb_valid,
    input  logic              mb_ready,
    output logic [9:0]        mb_x,
    output logic [9:0]        mb_y,
    output logic [4*DW-1:0]   ac_levels,
    output logic [2*DW-1:0]   uv_levels,
    output logic [255:0]      dc_levels,
    output logic [31:0]       mode_i16,
    output logic [127:0]      mode_i4,
    output logic [31:0]       mode_uv,
    output logic [31:0]       nz,
    output logic [7:0]        mbtype,
    output logic [7:0]        skipped,
    output logic [31:0]       max_edge,
    output logic              format_err,
    output logic              done
);
    localparam int CW = $clog2(BEATS + 1);
    localparam logic [CW-1:0] NBEATS = CW'(BEATS);
    localparam logic [CW-1:0] LAST   = CW'(BEATS - 1);
    // Reserved bits of the trailer beat: [1023:960], [927:912], [895:480]
    localparam logic [1023:0] RSV_MASK = {{64{1'b1}}, 32'h0, 16'hffff, 16'h0,
                                          {416{1'b1}}, 480'h0};

    typedef enum logic [1:0] {IDLE, COLLECT, PRESENT, FINISH} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   issued, recv;
    logic            rd_d1;
    logic [9:0]      x, y;
    logic [DW-1:0]   rec [BEATS];
    logic            last_mb, accept, trailer_in;

    assign last_mb    = (x == w1) && (y == h1);
    assign accept     = (state == PRESENT) && mb_ready;
    assign trailer_in = (state == COLLECT) && rd_d1 && (recv == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)      state_nx = COLLECT;
            COLLECT: if (trailer_in) state_nx = PRESENT;
            PRESENT: if (mb_ready)   state_nx = last_mb ? FINISH : COLLECT;
            FINISH:                  state_nx = IDLE;
            default:                 state_nx = IDLE;
        endcase
    end

    always_comb begin
        fifo_rd  = (state == COLLECT) && !fifo_empty && (issued < NBEATS);
        mb_valid = (state == PRESENT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued     <= '0;
            recv       <= '0;
            rd_d1      <= 1'b0;
            x          <= '0;
            y          <= '0;
            format_err <= 1'b0;
            done       <= 1'b0;
        end else begin
            rd_d1 <= fifo_rd;
            done  <= (state == FINISH);
            if (state == IDLE && start) begin
                x          <= '0;
                y          <= '0;
                issued     <= '0;
                recv       <= '0;
                format_err <= 1'b0;
            end
            if (fifo_rd) issued <= issued + 1'b1;
            if (state == COLLECT && rd_d1) recv <= recv + 1'b1;
            if (trailer_in && |(fifo_dout[1023:0] & RSV_MASK)) format_err <= 1'b1;
            if (accept) begin
                issued <= '0;
                recv   <= '0;
                if (!last_mb) begin
                    x <= (x == w1) ? 10'd0 : x + 10'd1;
                    if (x == w1) y <= y + 10'd1;
                end
            end
        end
    end

    // In-flight beats land in the slot named by recv, one cycle after their pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < BEATS; b++) rec[b] <= '0;
        end else if (state == COLLECT && rd_d1) begin
            for (int b = 0; b < BEATS; b++)
                if (recv == CW'(b)) rec[b] <= fifo_dout;
        end
    end

    assign mb_x      = x;
    assign mb_y      = y;
    assign ac_levels = {rec[3], rec[2], rec[1], rec[0]};
    assign uv_levels = {rec[5], rec[4]};
    assign dc_levels = rec[BEATS-1][255:0];
    assign mode_i16  = rec[BEATS-1][287:256];
    assign mode_i4   = rec[BEATS-1][415:288];
    assign mode_uv   = rec[BEATS-1][447:416];
    assign nz        = rec[BEATS-1][479:448];
    assign mbtype    = rec[BEATS-1][903:896];
    assign skipped   = rec[BEATS-1][911:904];
    assign max_edge  = rec[BEATS-1][959:928];

endmodule
